output_port_lock: RTL
=====================

OUTPUT_PORT_LOCK -- requirements
Module: output_port_lock

Interface
REQ-001 SHALL have parameter CREDITS, default 4, giving the downstream buffer depth in flits (range 1..7).
REQ-002 SHALL have parameter CW, default 3, giving the credit counter width (must satisfy 2^CW > CREDITS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port gnt_in, input, 4 bits: one-hot grant from the upstream priority stage; bit i grants input VC i.
REQ-006 SHALL have port flit_valid, input, 4 bits: input VC i has a flit ready.
REQ-007 SHALL have port flit_tail, input, 4 bits: the flit presented by input VC i is the packet tail.
REQ-008 SHALL have port credit_in, input, 1 bit: one-cycle pulse returning one downstream buffer slot.
REQ-009 SHALL have port arb_en, output, 1 bit: enable to the priority stage; high when a new packet may be granted.
REQ-010 SHALL have port sel, output, 2 bits: index of the locked input VC.
REQ-011 SHALL have port sel_valid, output, 1 bit: the port is locked to sel.
REQ-012 SHALL have port vc_ack, output, 4 bits: one-hot pop to input VC sel in each cycle a flit is forwarded.
REQ-013 SHALL have port flit_fwd, output, 1 bit: a flit crosses to the output this cycle.
REQ-014 SHALL have port credit_cnt, output, CW bits: available downstream credits.
REQ-015 SHALL have port credit_err, output, 1 bit: sticky flag raised when a credit is returned while the counter is already full.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and LOCKED.
REQ-017 SHALL drive arb_en = (state==IDLE) & (credit_cnt != 0), combinationally from registered state.
REQ-018 In IDLE with gnt_in != 0, SHALL load sel with the binary index of the lowest set gnt_in bit, set sel_valid, and enter LOCKED on the next edge.
REQ-019 In IDLE, gnt_in SHALL be ignored while arb_en is low; in LOCKED, gnt_in SHALL always be ignored.
REQ-020 No flit SHALL be forwarded in the grant cycle; forwarding starts the first cycle in LOCKED (grant-to-first-forward latency = 1 cycle).
REQ-021 In LOCKED, flit_fwd SHALL be combinational: flit_valid[sel] & (credit_cnt != 0).
REQ-022 vc_ack SHALL equal the one-hot decode of sel when flit_fwd is high, and 0 otherwise.
REQ-023 When flit_fwd is high and flit_tail[sel] is high, the block SHALL clear sel_valid and return to IDLE on the next edge; sel SHALL hold its last value.
REQ-024 The credit counter SHALL update once per clock: fwd only -> -1; credit_in only -> +1; both -> unchanged; neither -> unchanged.
REQ-025 When credit_in is high, credit_cnt == CREDITS and no forward occurs, the count SHALL stay at CREDITS and credit_err SHALL set and remain set until reset.
REQ-026 When credit_cnt == 0, forwarding SHALL stall with the lock held; a credit_in at zero SHALL allow forwarding from the following cycle.
REQ-027 A single-flit packet (head is tail) SHALL occupy LOCKED for exactly one forwarding cycle and then return to IDLE.
REQ-028 The earliest re-arbitration SHALL be the cycle after the IDLE return, i.e. one bubble cycle between packets.

Reset
REQ-029 On reset assertion, outputs SHALL take immediately: state=IDLE, sel=0, sel_valid=0, credit_cnt=CREDITS, credit_err=0; hence arb_en=1, vc_ack=0, flit_fwd=0.
REQ-030 Reset asserted mid-packet SHALL abandon the lock with no further vc_ack; credits SHALL reload to CREDITS.
REQ-031 After reset deasserts, operation SHALL resume on the first rising edge.

Verification
REQ-032 Scenario: gnt_in=4'b0100, VC2 sends a 3-flit packet with credits available -> sel=2, sel_valid=1 next cycle, vc_ack=4'b0100 for 3 cycles, IDLE and arb_en=1 after the tail.
REQ-033 Scenario: CREDITS=4, no credit_in, VC0 sends a 6-flit packet -> 4 forwards, credit_cnt=0, stall; two credit_in pulses -> remaining 2 flits forwarded.
REQ-034 Scenario: credit_in and flit_fwd in the same cycle at credit_cnt=2 -> credit_cnt stays 2.
REQ-035 Scenario: credit_in at credit_cnt=4 with no forward -> credit_cnt=4, credit_err=1 and remaining 1.
REQ-036 Scenario: reset pulse during the 2nd flit of a packet -> sel_valid=0, vc_ack=0, credit_cnt=4 immediately; gnt_in=4'b0001 after release -> sel=0 locked.
REQ-037 Scenario: gnt_in=4'b1000 while LOCKED to VC1 -> ignored, sel stays 1 until the tail.

Source files
------------

// File: rtl/output_port_lock.sv
// Output-port lock: holds the port for one input VC from grant until its tail flit,
// forwarding only while downstream credits remain.
module output_port_lock #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    gnt_in,
  input  logic [3:0]    flit_valid,
  input  logic [3:0]    flit_tail,
  input  logic          credit_in,
  output logic          arb_en,
  output logic [1:0]    sel,
  output logic          sel_valid,
  output logic [3:0]    vc_ack,
  output logic          flit_fwd,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_err
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [CW-1:0] CreditsFull = CW'(CREDITS);

  logic [0:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    gnt_idx;
  logic          have_credit;

  assign have_credit = (cnt_q != '0);
  assign arb_en      = (state_q == StIdle) & have_credit;
  assign flit_fwd    = (state_q == StLocked) & flit_valid[sel_q] & have_credit;
  assign vc_ack      = flit_fwd ? (4'b0001 << sel_q) : 4'b0000;
  assign sel         = sel_q;
  assign sel_valid   = (state_q == StLocked);
  assign credit_cnt  = cnt_q;
  assign credit_err  = err_q;

  // Lowest set grant bit wins if more than one is asserted.
  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (gnt_in[i]) gnt_idx = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == StIdle) begin
      if (arb_en && (gnt_in != 4'b0000)) begin
        sel_d   = gnt_idx;
        state_d = StLocked;
      end
    end else if (flit_fwd && flit_tail[sel_q]) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (flit_fwd && !credit_in) begin
      cnt_d = cnt_q - 1'b1;
    end else if (credit_in && !flit_fwd) begin
      if (cnt_q == CreditsFull) err_d = 1'b1;
      else                      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      cnt_q   <= CreditsFull;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
